// File: rtl/im_access_ctrl_pkg.sv
// rtl/im_access_ctrl_pkg.sv - shared instruction-memory map constants and controller state encoding
package im_access_ctrl_pkg;

  // Instruction memory geometry and text-segment placement
  localparam int          IMSIZE        = 4096;
  localparam int          ADDR_W        = 12;
  localparam logic [31:0] TEXT_BASE     = 32'h0000_3000;
  localparam logic [31:0] TEXT_SPAN     = 32'(4 * IMSIZE);

  // Exception-handler region start; loader writes here need privilege
  localparam logic [31:0] HANDLER_BASE  = 32'h0000_4180;

  // Loader may win at most this many grants in a row while fetch waits
  localparam int          LD_MAX_STREAK = 4;
  localparam int          STREAK_W      = $clog2(LD_MAX_STREAK + 1);

  // Controller state: clearing memory after reset, then serving requests
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } im_state_e;

endpackage

// File: rtl/im_access_ctrl_addr_check.sv
// rtl/im_access_ctrl_addr_check.sv - byte address to word index with range and alignment check
module im_addr_check
  import im_access_ctrl_pkg::*;
(
  input  logic [31:0]       addr,
  output logic [ADDR_W-1:0] idx,
  output logic              bad
);

  logic [31:0] off;
  logic        misaligned;
  logic        out_of_range;

  // Offset from the text base; an address below the base wraps to a huge
  // offset, so a single unsigned compare covers both ends of the window.
  assign off          = addr - TEXT_BASE;
  assign idx          = off[ADDR_W+1:2];
  assign misaligned   = |off[1:0];
  assign out_of_range = (off >= TEXT_SPAN);
  assign bad          = misaligned | out_of_range;

endmodule

// File: rtl/im_access_ctrl.sv
// rtl/im_access_ctrl.sv - instruction memory controller: post-reset clear, fetch/loader arbitration
module im_access_ctrl
  import im_access_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [31:0]       f_pc,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [31:0]       f_instr,
  output logic              f_adel,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_priv,
  output logic              ld_ack,
  output logic              ld_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              init_done
);

  im_state_e            state, state_nxt;
  logic [ADDR_W-1:0]    clear_cnt, clear_nxt;
  logic [STREAK_W-1:0]  streak, streak_nxt;
  logic                 resp_pending;
  logic                 resp_bad;

  logic [ADDR_W-1:0]    f_idx;
  logic                 f_bad;
  logic [ADDR_W-1:0]    ld_idx;
  logic                 ld_bad;
  logic                 ld_hi;
  logic                 ld_reject;
  logic                 fetch_starved;

  im_addr_check u_f_check (
    .addr (f_pc),
    .idx  (f_idx),
    .bad  (f_bad)
  );

  im_addr_check u_ld_check (
    .addr (ld_addr),
    .idx  (ld_idx),
    .bad  (ld_bad)
  );

  assign ld_hi         = (ld_addr >= HANDLER_BASE);
  assign ld_reject     = ld_bad | (ld_hi & ~ld_priv);
  assign fetch_starved = f_req & (streak == STREAK_W'(LD_MAX_STREAK));

  // State, clear pointer, loader streak and the one-deep response tracker
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      clear_cnt    <= '0;
      streak       <= '0;
      resp_pending <= 1'b0;
      resp_bad     <= 1'b0;
    end else begin
      state        <= state_nxt;
      clear_cnt    <= clear_nxt;
      streak       <= streak_nxt;
      resp_pending <= f_gnt;
      resp_bad     <= f_gnt & f_bad;
    end
  end

  // Next state, arbitration and memory strobes; everything idles while reset is held
  always_comb begin
    state_nxt  = state;
    clear_nxt  = clear_cnt;
    streak_nxt = streak;
    f_gnt      = 1'b0;
    ld_ack     = 1'b0;
    ld_err     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!reset) begin
      case (state)
        INIT: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = clear_cnt;
          clear_nxt = clear_cnt + ADDR_W'(1);
          if (clear_cnt == ADDR_W'(IMSIZE - 1)) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (ld_req && !fetch_starved) begin
            ld_ack = 1'b1;
            if (ld_reject) begin
              ld_err = 1'b1;
            end else begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = ld_idx;
              mem_wdata = ld_wdata;
            end
            streak_nxt = f_req ? streak + STREAK_W'(1) : '0;
          end else if (f_req) begin
            f_gnt      = 1'b1;
            streak_nxt = '0;
            if (!f_bad) begin
              mem_en   = 1'b1;
              mem_addr = f_idx;
            end
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  // A flush in the response cycle kills only that response; read data passes straight through
  assign f_valid   = resp_pending & ~f_flush & ~reset;
  assign f_adel    = f_valid & resp_bad;
  assign f_instr   = (f_valid && !resp_bad) ? mem_rdata : 32'h0;
  assign init_done = (state == RUN) & ~reset;

endmodule

// File: tb/tb_im_access_ctrl.sv
// tb/tb_im_access_ctrl.sv - directed scoreboard bench for im_access_ctrl
module tb_im_access_ctrl;
  import im_access_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req, f_flush, f_gnt, f_valid, f_adel;
  logic [31:0]       f_pc, f_instr;
  logic              ld_req, ld_priv, ld_ack, ld_err;
  logic [31:0]       ld_addr, ld_wdata;
  logic              mem_en, mem_we, init_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  typedef struct packed {
    logic [31:0] instr;
    logic        adel;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] mem [0:IMSIZE-1];
  logic [31:0] exp_mem [0:IMSIZE-1];
  int          total = 0;
  int          bad = 0;

  im_access_ctrl dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_pc(f_pc), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_valid(f_valid), .f_instr(f_instr), .f_adel(f_adel),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_priv(ld_priv),
    .ld_ack(ld_ack), .ld_err(ld_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h3000) >> 2);
  endfunction

  always @(negedge clk) begin
    if (f_valid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", f_valid, 1'b0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_instr", f_instr, e.instr);
        chk("resp_adel", f_adel, e.adel);
      end
    end
  end

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ea);
    int n = 0;
    f_req = 1'b1;
    f_pc  = pc;
    @(negedge clk);
    while (!f_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_gnt", f_gnt, 1'b1);
    chk("fetch_mem_en", mem_en, !ea);
    if (f_gnt) sb.push_back('{instr: ei, adel: ea});
    @(posedge clk); #1;
    f_req = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic p, input logic e_err);
    int n = 0;
    ld_req   = 1'b1;
    ld_addr  = a;
    ld_wdata = d;
    ld_priv  = p;
    @(negedge clk);
    while (!ld_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ld_ack", ld_ack, 1'b1);
    chk("ld_err", ld_err, e_err);
    chk("ld_mem_en", mem_en, !e_err);
    if (!e_err) begin
      chk("ld_mem_addr", 32'(mem_addr), widx(a));
      chk("ld_mem_wdata", mem_wdata, d);
      if (ld_ack) exp_mem[widx(a)] = d;
    end
    @(posedge clk); #1;
    ld_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_errs, gnt_errs, early;
    int k;
    logic [5:0] ack_pat, gnt_pat;
    logic acked, granted;

    for (int i = 0; i < IMSIZE; i++) begin
      mem[i]     = 32'hDEAD_0000 | i;
      exp_mem[i] = 32'h0;
    end
    reset = 1'b1; f_req = 1'b0; f_pc = 32'h0; f_flush = 1'b0;
    ld_req = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0; ld_priv = 1'b0;
    mem_rdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_f_valid", f_valid, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_f_instr", f_instr, 32'h0);
    @(posedge clk); #1;

    // Clear sweep with a fetch already waiting
    reset = 1'b0;
    f_req = 1'b1;
    f_pc  = 32'h3004;
    clr_errs = 0; gnt_errs = 0; early = 0;
    for (int n = 1; n <= IMSIZE; n++) begin
      @(negedge clk);
      if (!(mem_en && mem_we && (32'(mem_addr) == n - 1) && mem_wdata == 32'h0)) clr_errs++;
      if (f_gnt || ld_ack) gnt_errs++;
      if (init_done) early++;
    end
    chk("init_clear_errs", clr_errs, 0);
    chk("init_gnt_errs", gnt_errs, 0);
    chk("init_done_early", early, 0);
    @(negedge clk);
    chk("init_done_4097", init_done, 1'b1);
    chk("first_fetch_gnt", f_gnt, 1'b1);
    chk("first_fetch_read", mem_en && !mem_we, 1'b1);
    if (f_gnt) sb.push_back('{instr: 32'h0, adel: 1'b0});
    @(posedge clk); #1;
    f_req = 1'b0;

    // Load then fetch the first word
    do_load(32'h3000, 32'h2408_0005, 1'b0, 1'b0);
    do_fetch(32'h3000, exp_mem[0], 1'b0);

    // Address errors
    do_fetch(32'h3002, 32'h0, 1'b1);
    do_fetch(32'h2FFC, 32'h0, 1'b1);
    do_fetch(32'h7000, 32'h0, 1'b1);
    do_fetch(32'h6FFC, exp_mem[IMSIZE-1], 1'b0);

    // Loader streak limit against a waiting fetch
    k = 0;
    ld_req = 1'b1; ld_addr = 32'h3020; ld_wdata = 32'd1; ld_priv = 1'b0;
    f_req = 1'b1;  f_pc = 32'h3000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acked   = ld_ack;
      granted = f_gnt;
      ack_pat[i] = acked;
      gnt_pat[i] = granted;
      if (acked) begin
        exp_mem[8 + k] = 32'(k + 1);
        k++;
      end
      if (granted) sb.push_back('{instr: exp_mem[0], adel: 1'b0});
      @(posedge clk); #1;
      ld_addr  = 32'h3020 + 32'(4 * k);
      ld_wdata = 32'(k + 1);
      if (granted) f_req = 1'b0;
    end
    ld_req = 1'b0;
    chk("streak_ack_pattern", 32'(ack_pat), 32'b101111);
    chk("streak_gnt_pattern", 32'(gnt_pat), 32'b010000);
    do_fetch(32'h302C, 32'd4, 1'b0);
    do_fetch(32'h3030, 32'd5, 1'b0);

    // Handler region privilege and a misaligned load
    do_load(32'h4180, 32'hAAAA_5555, 1'b0, 1'b1);
    do_fetch(32'h4180, exp_mem[1120], 1'b0);
    do_load(32'h4180, 32'hAAAA_5555, 1'b1, 1'b0);
    do_fetch(32'h4180, 32'hAAAA_5555, 1'b0);
    do_load(32'h3001, 32'h1234_5678, 1'b1, 1'b1);

    // Flush of a lone response
    f_req = 1'b1; f_pc = 32'h3000;
    @(negedge clk);
    chk("flush_gnt", f_gnt, 1'b1);
    @(posedge clk); #1;
    f_req = 1'b0; f_flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", f_valid, 1'b0);
    @(posedge clk); #1;
    f_flush = 1'b0;

    // Flush alongside a new grant keeps the new one
    f_req = 1'b1; f_pc = 32'h3000;
    @(negedge clk);
    chk("flush2_gnt_old", f_gnt, 1'b1);
    @(posedge clk); #1;
    f_pc = 32'h302C; f_flush = 1'b1;
    @(negedge clk);
    chk("flush2_gnt_new", f_gnt, 1'b1);
    chk("flush2_valid", f_valid, 1'b0);
    if (f_gnt) sb.push_back('{instr: 32'd4, adel: 1'b0});
    @(posedge clk); #1;
    f_req = 1'b0; f_flush = 1'b0;
    @(negedge clk);
    chk("flush2_resp_valid", f_valid, 1'b1);
    @(posedge clk); #1;

    // Reset mid-stream
    f_req = 1'b1; f_pc = 32'h3000;
    @(negedge clk);
    chk("midrst_gnt", f_gnt, 1'b1);
    @(posedge clk); #1;
    f_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", f_valid, 1'b0);
    chk("midrst_mem_en", mem_en, 1'b0);
    chk("midrst_init_done", init_done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("restart_valid", f_valid, 1'b0);
    chk("restart_clear", mem_en && mem_we, 1'b1);
    chk("restart_addr", 32'(mem_addr), 32'h0);
    chk("restart_init_done", init_done, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart_addr1", 32'(mem_addr), 32'h1);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
